// File: rtl/stone_place_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stone_place_decoder: turns an encoded window hit into a board coordinate    |
// | and streams up to two stones per move.   Rev 1.0                            |
// +----------------------------------------------------------------------------+
module stone_place_decoder #(
    parameter int BOARD = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_idx,
    input  logic [4:0] in_row,
    input  logic [4:0] in_col,
    input  logic [1:0] in_dir,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_row,
    output logic [4:0] out_col,
    output logic       out_second,
    output logic       move_done,
    output logic [1:0] move_count,
    output logic       err
);

    localparam logic [5:0] c_board = 6'(BOARD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SEND  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [4:0] r_row;
    logic [4:0] r_col;
    logic [1:0] r_dir;
    logic       r_last;
    logic       r_hold;
    logic [1:0] r_count;
    logic [4:0] r_first_row;
    logic [4:0] r_first_col;
    logic [4:0] r_out_row;
    logic [4:0] r_out_col;
    logic       r_out_second;

    logic [5:0] w_step;
    logic [5:0] w_crow;
    logic [5:0] w_ccol;
    logic       w_off;
    logic       w_none;
    logic       w_err;
    logic       w_dup;
    logic       w_fire;
    logic       w_accept;

    assign w_accept = in_valid && in_ready;
    assign w_step   = {3'b000, r_idx};

    // 6-bit arithmetic: negative results show up in bit 5, large ones exceed c_board
    always_comb begin
        w_crow = {1'b0, r_row};
        w_ccol = {1'b0, r_col};
        case (r_dir)
            2'd0: w_ccol = {1'b0, r_col} + w_step;
            2'd1: w_crow = {1'b0, r_row} + w_step;
            2'd2: begin
                w_crow = {1'b0, r_row} + w_step;
                w_ccol = {1'b0, r_col} + w_step;
            end
            default: begin
                w_crow = {1'b0, r_row} + w_step;
                w_ccol = {1'b0, r_col} - w_step;
            end
        endcase
    end

    assign w_off  = w_crow[5] || w_ccol[5] || (w_crow >= c_board) || (w_ccol >= c_board);
    assign w_none = (r_idx == 3'd7);
    assign w_err  = !w_none && ((r_idx == 3'd6) || w_off);
    assign w_dup  = (r_count != 2'd0) && (w_crow[4:0] == r_first_row)
                    && (w_ccol[4:0] == r_first_col);
    assign w_fire = (r_state == CALC) && !w_none && !w_err && !w_dup;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = CALC;
            CALC: begin
                if (w_fire)      w_next = SEND;
                else if (r_last) w_next = CLOSE;
                else             w_next = IDLE;
            end
            SEND: begin
                if (out_ready) begin
                    if ((r_count == 2'd1) || r_last) w_next = CLOSE;
                    else                              w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // r_hold stretches a discard-to-IDLE path so acceptances stay 3 cycles apart
    assign in_ready   = (r_state == IDLE) && !r_hold;
    assign out_valid  = (r_state == SEND);
    assign move_done  = (r_state == CLOSE);
    assign move_count = (r_state == CLOSE) ? r_count : 2'd0;
    assign err        = (r_state == CALC) && w_err;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_second = r_out_second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 3'd0;
            r_row        <= 5'd0;
            r_col        <= 5'd0;
            r_dir        <= 2'd0;
            r_last       <= 1'b0;
            r_hold       <= 1'b0;
            r_count      <= 2'd0;
            r_first_row  <= 5'd0;
            r_first_col  <= 5'd0;
            r_out_row    <= 5'd0;
            r_out_col    <= 5'd0;
            r_out_second <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == CALC) && (w_next == IDLE);
            if (w_accept) begin
                r_idx  <= in_idx;
                r_row  <= in_row;
                r_col  <= in_col;
                r_dir  <= in_dir;
                r_last <= in_last;
            end
            if (w_fire) begin
                r_out_row    <= w_crow[4:0];
                r_out_col    <= w_ccol[4:0];
                r_out_second <= (r_count == 2'd1);
            end
            if ((r_state == SEND) && out_ready) begin
                r_count <= r_count + 2'd1;
                if (r_count == 2'd0) begin
                    r_first_row <= r_out_row;
                    r_first_col <= r_out_col;
                end
            end
            if (r_state == CLOSE) begin
                r_count     <= 2'd0;
                r_first_row <= 5'd0;
                r_first_col <= 5'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stone_place_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stone_place_decoder: random and directed stimulus against a move model.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_stone_place_decoder;

    localparam int BOARD = 19;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [4:0] in_row;
    logic [4:0] in_col;
    logic [1:0] in_dir;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       out_second;
    logic       move_done;
    logic [1:0] move_count;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;
    // move model: stones emitted so far and the first one
    int m_cnt   = 0;
    int m_fr    = 0;
    int m_fc    = 0;

    stone_place_decoder #(.BOARD(BOARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_row     (in_row),
        .in_col     (in_col),
        .in_dir     (in_dir),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_second (out_second),
        .move_done  (move_done),
        .move_count (move_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        check_val("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // One input through its full life; called and returning on a negedge.
    task automatic send_one(input int idx, input int row, input int col, input int dir,
                            input int last, input int stall);
        int  r, c;
        int  kind; // 0 none, 1 err, 2 dup, 3 stone
        bit  closing;
        r = row;
        c = col;
        case (dir)
            0: c = col + idx;
            1: r = row + idx;
            2: begin r = row + idx; c = col + idx; end
            default: begin r = row + idx; c = col - idx; end
        endcase
        if (idx == 7)                                    kind = 0;
        else if (idx == 6 || r < 0 || r >= BOARD || c < 0 || c >= BOARD) kind = 1;
        else if (m_cnt == 1 && r == m_fr && c == m_fc)   kind = 2;
        else                                             kind = 3;

        wait_ready();
        in_valid = 1'b1;
        in_idx   = 3'(idx);
        in_row   = 5'(row);
        in_col   = 5'(col);
        in_dir   = 2'(dir);
        in_last  = last[0];
        @(negedge clk);
        in_valid = 1'b0;
        check_val("calc_err", {31'd0, err}, {31'd0, kind == 1});
        check_val("calc_ovalid", {31'd0, out_valid}, 32'd0);
        check_val("calc_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check_val("err_once", {31'd0, err}, 32'd0);
        if (kind == 3) begin
            for (int s = 0; s <= stall; s++) begin
                check_val("send_valid", {31'd0, out_valid}, 32'd1);
                check_val("send_row", {27'd0, out_row}, 32'(r));
                check_val("send_col", {27'd0, out_col}, 32'(c));
                check_val("send_second", {31'd0, out_second}, {31'd0, m_cnt == 1});
                check_val("send_ready", {31'd0, in_ready}, 32'd0);
                check_val("send_done", {31'd0, move_done}, 32'd0);
                out_ready = (s == stall);
                @(negedge clk);
            end
            out_ready = 1'b0;
            m_cnt++;
            if (m_cnt == 1) begin
                m_fr = r;
                m_fc = c;
            end
            closing = (m_cnt == 2) || (last != 0);
        end else begin
            closing = (last != 0);
        end
        check_val("post_ovalid", {31'd0, out_valid}, 32'd0);
        if (closing) begin
            check_val("done", {31'd0, move_done}, 32'd1);
            check_val("count", {30'd0, move_count}, 32'(m_cnt));
            m_cnt = 0;
            m_fr  = 0;
            m_fc  = 0;
            @(negedge clk);
            check_val("done_pulse", {31'd0, move_done}, 32'd0);
            check_val("idle_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            check_val("no_done", {31'd0, move_done}, 32'd0);
            // a discard back to IDLE must not allow an acceptance 2 cycles after the last
            check_val("idle_ready", {31'd0, in_ready}, {31'd0, kind == 3});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = 3'd0;
        in_row    = 5'd0;
        in_col    = 5'd0;
        in_dir    = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check_val("rst_outs", {21'd0, out_row, out_col, out_second}, 32'd0);
        check_val("rst_done", {28'd0, move_done, move_count, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_one(3, 4, 2, 0, 0, 0);     // (4,5)
        send_one(1, 10, 10, 3, 0, 0);   // (11,9) second, closes with 2
        send_one(5, 16, 0, 1, 0, 0);    // row 21 off board
        send_one(0, 3, 3, 0, 0, 0);     // first stone (3,3)
        send_one(2, 1, 3, 1, 1, 0);     // duplicate (3,3), closes with 1
        send_one(1, 0, 0, 2, 1, 5);     // stalled 5 cycles
        send_one(7, 0, 0, 0, 1, 0);     // no cell, empty move
        send_one(6, 2, 2, 0, 0, 0);     // reserved index
        send_one(3, 1, 2, 3, 0, 0);     // col 2-3 < 0

        // reset in the middle of a second-stone SEND
        send_one(0, 7, 7, 0, 0, 0);
        wait_ready();
        in_valid = 1'b1;
        in_idx   = 3'd0;
        in_row   = 5'd8;
        in_col   = 5'd8;
        in_dir   = 2'd0;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ovalid", {31'd0, out_valid}, 32'd0);
        check_val("arst_ready", {31'd0, in_ready}, 32'd1);
        check_val("arst_outs", {21'd0, out_row, out_col, out_second}, 32'd0);
        @(negedge clk);
        check_val("arst_done", {31'd0, move_done}, 32'd0);
        rst_n = 1'b1;
        m_cnt = 0;
        m_fr  = 0;
        m_fc  = 0;
        @(negedge clk);
        send_one(0, 8, 8, 0, 1, 0);     // fresh move: not a second stone

        for (int t = 0; t < 300; t++) begin
            send_one(int'($urandom_range(0, 7)), int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 22)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stone_place_decoder.md
STONE_PLACE_DECODER -- requirements
Module: stone_place_decoder

Interface
REQ-001 SHALL have parameter BOARD, default 19, meaning board edge length in cells (legal coordinates 0..BOARD-1).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning an encoded window result is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an input this cycle.
REQ-006 SHALL have port in_idx, input, 3, meaning empty-cell index within the 6-cell window: 0..5 is a cell, 7 is no cell, 6 is reserved.
REQ-007 SHALL have ports in_row and in_col, input, 5 each, meaning board coordinates of window cell 0.
REQ-008 SHALL have port in_dir, input, 2, meaning window direction: 0 is +col, 1 is +row, 2 is +row+col, 3 is +row-col.
REQ-009 SHALL have port in_last, input, 1, meaning this input is the final window of the current move search.
REQ-010 SHALL have port out_valid, output, 1, meaning a decoded stone coordinate is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream accepts the stone.
REQ-012 SHALL have ports out_row and out_col, output, 5 each, meaning the decoded stone coordinate.
REQ-013 SHALL have port out_second, output, 1, meaning the presented stone is the second stone of the move.
REQ-014 SHALL have port move_done, output, 1, meaning a one-cycle pulse when the move is closed.
REQ-015 SHALL have port move_count, output, 2, meaning the number of stones emitted in the closed move (0..2); valid only while move_done=1.
REQ-016 SHALL have port err, output, 1, meaning a one-cycle pulse when an input is discarded as off-board or reserved.

Function
REQ-017 SHALL implement the FSM states IDLE, CALC, SEND and CLOSE.
REQ-018 SHALL drive in_ready=1 only in IDLE; an input is accepted when in_valid=1 and in_ready=1, and all input fields are registered on acceptance.
REQ-019 SHALL go from IDLE to CALC on acceptance and spend exactly one cycle in CALC.
REQ-020 SHALL compute the stone coordinate in CALC as follows:
- dir 0: (row, col+idx)
- dir 1: (row+idx, col)
- dir 2: (row+idx, col+idx)
- dir 3: (row+idx, col-idx)
- all arithmetic at 6 bits signed, so results below 0 or at least BOARD are detected without wrap-around.
REQ-021 SHALL exit CALC as follows:
- idx=7: no stone and no err.
- idx=6 or off-board result: err pulse for one cycle.
- coordinate equal to the first stone already emitted in this move: silent discard.
- otherwise: go to SEND.
- in every discard case: go to CLOSE if the registered in_last=1, else to IDLE.
REQ-022 SHALL assert out_valid in SEND and hold out_row, out_col and out_second stable until out_ready=1; out_second SHALL be 1 iff one stone was already emitted in this move.
REQ-023 SHALL, on the out_valid and out_ready handshake, increment the stone counter and store the coordinate as the first stone when the counter was 0.
REQ-024 SHALL, after that handshake, go to CLOSE if the counter reaches 2 or the registered in_last=1, else to IDLE.
REQ-025 SHALL pulse move_done for exactly one cycle in CLOSE with move_count equal to the stone counter, clear the counter and first-stone register, and return to IDLE.
REQ-026 SHALL give every input, including a second stone, a minimum latency of 2 cycles from acceptance to out_valid, and a minimum of 3 cycles between consecutive acceptances.
REQ-027 SHALL never present out_valid and move_done in the same cycle.

Reset
REQ-028 SHALL, while rst_n=0, immediately force the FSM to IDLE, the stone counter to 0 and the first-stone register to 0.
REQ-029 SHALL, while rst_n=0, immediately force the outputs to in_ready=1 (IDLE), out_valid=0, out_row=0, out_col=0, out_second=0, move_done=0, move_count=0 and err=0.
REQ-030 SHALL, on a reset during SEND or CLOSE, abandon the pending stone or move with no move_done.

Verification
REQ-031 SHALL cover this scenario: idx=3, row=4, col=2, dir=0, last=0, with out_ready=1 -> out (4,5) with out_second=0 two cycles after acceptance; no move_done.
REQ-032 SHALL cover this scenario: a second input idx=1, row=10, col=10, dir=3 -> out (11,9) with out_second=1, then move_done=1 with move_count=2 the next cycle.
REQ-033 SHALL cover this scenario: idx=5, row=16, col=0, dir=1 -> err pulse, no out_valid, counter unchanged.
REQ-034 SHALL cover this scenario: a first stone at (3,3), then an input decoding to (3,3) with last=1 -> no second out_valid, move_done with move_count=1.
REQ-035 SHALL cover this scenario: out_ready held at 0 for 5 cycles in SEND -> out_valid and the data stay stable and in_ready=0 throughout; the transfer completes on the first cycle with out_ready=1.
REQ-036 SHALL cover this scenario: rst_n driven low mid-SEND -> out_valid=0 asynchronously, and after release the next move starts with out_second=0.
